// File: rtl/fft_spi_pkg.sv
// Shared definitions for the FFT SPI stream output stage: FSM encoding,
// CRC-8 constants and a frame-length helper.
package fft_spi_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CS_SETUP = 3'd1,
      SHIFT    = 3'd2,
      GAP      = 3'd3,
      CS_HOLD  = 3'd4,
      DONE     = 3'd5
   } state_t;

   localparam logic [7:0] CRC8_POLY         = 8'h07;
   localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;

   // One MSB-first CRC-8 step for a single data bit.
   function automatic logic [7:0] crc8_bit(input logic [7:0] crc, input logic b);
      return {crc[6:0], 1'b0} ^ (((crc[7] ^ b) == 1'b1) ? CRC8_POLY : 8'h00);
   endfunction

   // Clock cycles that cs stays low for a frame of the given number of words.
   function automatic int frame_cycles(input int words, input int w, input int gap,
                                       input int cphb);
      return (2 + words * 2 * w + (words - 1) * gap) * cphb;
   endfunction

endpackage

// File: rtl/fft_spi_stream_out_tx.sv
// One-word SPI transmitter: half-bit timer, SCLK generator and MSB-first
// shift register. The sequencer in the top module decides what to load.
module spi_word_tx
   import fft_spi_pkg::*;
#(
   parameter int W                 = 8,
   parameter int CPOL              = 0,
   parameter int CPHA              = 0,
   parameter int CLKS_PER_HALF_BIT = 2
) (
   input  logic         clk,
   input  logic         rst_l,
   input  logic         en,
   input  logic         shift_en,
   input  logic         load,
   input  logic [W-1:0] word,
   output logic         half_tick,
   output logic         word_done,
   output logic         sclk,
   output logic         mosi
);

   localparam int HBW = $clog2(CLKS_PER_HALF_BIT);
   localparam int EW  = $clog2(2 * W);
   localparam logic [HBW-1:0] HB_LAST = HBW'(CLKS_PER_HALF_BIT - 1);
   localparam logic [EW-1:0]  E_LAST  = EW'(2 * W - 1);

   logic [HBW-1:0] hb_q, hb_d;
   logic [EW-1:0]  edge_q, edge_d;
   logic [W-1:0]   sr_q, sr_d;
   logic           sclk_q, sclk_d;
   logic           shift_now;

   always_comb begin
      half_tick = en && (hb_q == HB_LAST);
      hb_d      = (!en || half_tick) ? '0 : hb_q + 1'b1;
      word_done = shift_en && half_tick && (edge_q == E_LAST);
      // edge_q is the index of the edge about to happen minus one: CPHA=0
      // shifts on trailing edges except the last, CPHA=1 on leading edges except the first.
      shift_now = (CPHA != 0) ? (!edge_q[0] && (edge_q != '0))
                              : (edge_q[0] && (edge_q != E_LAST));
      sclk_d = sclk_q;
      edge_d = edge_q;
      sr_d   = sr_q;
      if (shift_en && half_tick) begin
         sclk_d = ~sclk_q;
         edge_d = edge_q + 1'b1;
         if (shift_now) sr_d = {sr_q[W-2:0], 1'b0};
      end
      if (load) begin
         sr_d   = word;
         edge_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         hb_q   <= '0;
         edge_q <= '0;
         sr_q   <= '0;
         sclk_q <= 1'(CPOL);
      end else begin
         hb_q   <= hb_d;
         edge_q <= edge_d;
         sr_q   <= sr_d;
         sclk_q <= sclk_d;
      end
   end

   assign sclk = sclk_q;
   assign mosi = sr_q[W-1];

endmodule

// File: rtl/fft_spi_stream_out.sv
// FFT result streamer: snapshots the result bus and sends sync, data (and,
// with FFT_SPI_CRC8_EN defined, a CRC-8 word) in one chip-select frame.
module fft_spi_stream_out
   import fft_spi_pkg::*;
#(
   parameter int         N                 = 16,
   parameter int         W                 = 8,
   parameter int         CPOL              = 0,
   parameter int         CPHA              = 0,
   parameter int         CLKS_PER_HALF_BIT = 2,
   parameter int         GAP_HALF_BITS     = 2,
   parameter logic [7:0] SYNC_WORD         = SYNC_WORD_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic [N*2*W-1:0] data_bus,
   input  logic             start_spi,
   input  logic             half_only,
   output logic             busy,
   output logic             done,
   output logic             sclk,
   output logic             mosi,
   output logic             cs,
   output logic [2:0]       state_dbg
);

   localparam int WCW = $clog2(2 * N + 2);
   localparam int GW  = (GAP_HALF_BITS > 1) ? $clog2(GAP_HALF_BITS) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_HALF_BITS - 1);
`ifdef FFT_SPI_CRC8_EN
   localparam int CRC_WORDS = 1;
`else
   localparam int CRC_WORDS = 0;
`endif

   state_t           state_q, state_d;
   logic [N*2*W-1:0] snap_q, snap_d;
   logic             half_q, half_d;
   logic [WCW-1:0]   wc_q, wc_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic [WCW-1:0]   elems, last_idx;
   logic             cs_low, load, half_tick, word_done, tx_mosi;
   logic [W-1:0]     load_word;

`ifdef FFT_SPI_CRC8_EN
   logic [7:0] crc_q, crc_d;

   function automatic logic [7:0] crc8_word(input logic [7:0] crc_in, input logic [W-1:0] w_in);
      logic [7:0] c;
      c = crc_in;
      for (int i = W - 1; i >= 0; i--) c = crc8_bit(c, w_in[i]);
      return c;
   endfunction
`endif

   assign elems    = half_q ? WCW'(N) : WCW'(2 * N);
   assign last_idx = elems + WCW'(CRC_WORDS);
   assign cs_low   = (state_q == CS_SETUP) || (state_q == SHIFT) ||
                     (state_q == GAP) || (state_q == CS_HOLD);

   always_comb begin
      state_d   = state_q;
      snap_d    = snap_q;
      half_d    = half_q;
      wc_d      = wc_q;
      gap_d     = gap_q;
      load      = 1'b0;
      load_word = '0;
`ifdef FFT_SPI_CRC8_EN
      crc_d     = crc_q;
`endif
      case (state_q)
         IDLE: begin
            if (start_spi) begin
               snap_d    = data_bus;
               half_d    = half_only;
               wc_d      = '0;
               gap_d     = '0;
               load      = 1'b1;
               load_word = W'(SYNC_WORD);
`ifdef FFT_SPI_CRC8_EN
               crc_d     = '0;
`endif
               state_d   = CS_SETUP;
            end
         end
         CS_SETUP: if (half_tick) state_d = SHIFT;
         SHIFT: begin
            // The next word is loaded as the current one ends so that it is
            // already on mosi during the gap (or the next CPHA=0 half-bit).
            if (word_done) begin
               if (wc_q == last_idx) begin
                  state_d = CS_HOLD;
               end else begin
                  wc_d  = wc_q + 1'b1;
                  gap_d = '0;
                  load  = 1'b1;
                  if (wc_q < elems) begin
                     load_word = snap_q[W-1:0];
                     snap_d    = snap_q >> W;
`ifdef FFT_SPI_CRC8_EN
                     crc_d     = crc8_word(crc_q, snap_q[W-1:0]);
                  end else begin
                     load_word = W'(crc_q);
`endif
                  end
                  state_d = (GAP_HALF_BITS > 0) ? GAP : SHIFT;
               end
            end
         end
         GAP: begin
            if (half_tick) begin
               if (gap_q == GAP_LAST) state_d = SHIFT;
               else                   gap_d   = gap_q + 1'b1;
            end
         end
         CS_HOLD: if (half_tick) state_d = DONE;
         DONE:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q <= IDLE;
         snap_q  <= '0;
         half_q  <= 1'b0;
         wc_q    <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
         half_q  <= half_d;
         wc_q    <= wc_d;
         gap_q   <= gap_d;
      end
   end

`ifdef FFT_SPI_CRC8_EN
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) crc_q <= '0;
      else        crc_q <= crc_d;
   end
`endif

   spi_word_tx #(
      .W                 (W),
      .CPOL              (CPOL),
      .CPHA              (CPHA),
      .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT)
   ) u_tx (
      .clk       (clk),
      .rst_l     (rst_l),
      .en        (cs_low),
      .shift_en  (state_q == SHIFT),
      .load      (load),
      .word      (load_word),
      .half_tick (half_tick),
      .word_done (word_done),
      .sclk      (sclk),
      .mosi      (tx_mosi)
   );

   assign cs        = ~cs_low;
   assign busy      = cs_low;
   assign done      = (state_q == DONE);
   assign mosi      = cs_low & tx_mosi;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_fft_spi_stream_out.sv
// Bench for fft_spi_stream_out: two configurations, an SPI slave monitor per
// instance, and a scoreboard of expected words and cs-low lengths.
module tb_fft_spi_stream_out;

   localparam int N0 = 4, W0 = 8,  GAP0 = 2, CPHB0 = 2;
   localparam int N1 = 1, W1 = 12, GAP1 = 0, CPHB1 = 3;
`ifdef FFT_SPI_CRC8_EN
   localparam int CRCW = 1;
`else
   localparam int CRCW = 0;
`endif

   // clock / reset
   logic clk = 1'b0;
   logic rst_l = 1'b0;
   always #5 clk = ~clk;

   logic start0 = 1'b0, half0 = 1'b0, start1 = 1'b0, half1 = 1'b0;
   logic [N0*2*W0-1:0] bus0 = '0;
   logic [N1*2*W1-1:0] bus1 = '0;
   logic busy0, done0, sclk0, mosi0, cs0, busy1, done1, sclk1, mosi1, cs1;
   logic [2:0] st0, st1;

   fft_spi_stream_out #(.N(N0), .W(W0), .CPOL(0), .CPHA(0), .CLKS_PER_HALF_BIT(CPHB0),
                        .GAP_HALF_BITS(GAP0)) u0 (
      .clk(clk), .rst_l(rst_l), .data_bus(bus0), .start_spi(start0), .half_only(half0),
      .busy(busy0), .done(done0), .sclk(sclk0), .mosi(mosi0), .cs(cs0), .state_dbg(st0));

   fft_spi_stream_out #(.N(N1), .W(W1), .CPOL(1), .CPHA(1), .CLKS_PER_HALF_BIT(CPHB1),
                        .GAP_HALF_BITS(GAP1)) u1 (
      .clk(clk), .rst_l(rst_l), .data_bus(bus1), .start_spi(start1), .half_only(half1),
      .busy(busy1), .done(done1), .sclk(sclk1), .mosi(mosi1), .cs(cs1), .state_dbg(st1));

   // scoreboard
   logic [31:0] exp0_q[$], exp1_q[$];
   int          len0_q[$], len1_q[$];
   int          n_tests = 0, n_fail = 0;

   logic [31:0] sh[2];
   int          bitcnt[2], lowcnt[2], highcnt[2], last_gap[2], done_cnt[2], inv_err[2];
   logic        prev_cs[2], prev_sclk[2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] crc_model(input logic [7:0] c_in, input logic [31:0] d, input int w);
      logic [7:0] c;
      logic       fb;
      c = c_in;
      for (int b = w - 1; b >= 0; b--) begin
         fb = c[7] ^ d[b];
         c  = {c[6:0], 1'b0};
         if (fb) c = c ^ 8'h07;
      end
      return c;
   endfunction

   function automatic int frame_len(input int words, input int w, input int gap, input int cphb);
      return (2 + words * 2 * w + (words - 1) * gap) * cphb;
   endfunction

   task automatic push_word(input int k, input logic [31:0] v);
      if (k == 0) exp0_q.push_back(v);
      else        exp1_q.push_back(v);
   endtask

   task automatic push_expect(input int k, input logic [31:0] el[8], input int e, input int w,
                              input int gap, input int cphb);
      logic [7:0] crc;
      crc = 8'h00;
      push_word(k, 32'h0000_00A5);
      for (int i = 0; i < e; i++) begin
         push_word(k, el[i]);
         crc = crc_model(crc, el[i], w);
      end
      if (CRCW != 0) push_word(k, {24'h0, crc});
      if (k == 0) len0_q.push_back(frame_len(1 + e + CRCW, w, gap, cphb));
      else        len1_q.push_back(frame_len(1 + e + CRCW, w, gap, cphb));
   endtask

   task automatic pop_word(input int k, output logic [31:0] v, output bit ok);
      ok = 1'b1;
      v  = '0;
      if (k == 0 && exp0_q.size() > 0)      v = exp0_q.pop_front();
      else if (k == 1 && exp1_q.size() > 0) v = exp1_q.pop_front();
      else                                  ok = 1'b0;
   endtask

   task automatic pop_len(input int k, output int v, output bit ok);
      ok = 1'b1;
      v  = 0;
      if (k == 0 && len0_q.size() > 0)      v = len0_q.pop_front();
      else if (k == 1 && len1_q.size() > 0) v = len1_q.pop_front();
      else                                  ok = 1'b0;
   endtask

   // SPI slave monitor for one instance, evaluated on the falling clk edge.
   task automatic mon(input int k, input logic cs, input logic sclk, input logic mosi,
                      input logic busy, input logic done, input logic cpol, input logic cpha,
                      input int w);
      logic        samp;
      logic [31:0] v, mask;
      int          l;
      bit          ok;
      if (!rst_l) begin
         bitcnt[k] = 0; lowcnt[k] = 0; highcnt[k] = 0;
         prev_cs[k] = 1'b1; prev_sclk[k] = cpol;
         return;
      end
      mask = (32'h1 << w) - 1;
      if (busy !== ~cs) inv_err[k]++;
      if (cs && (mosi !== 1'b0 || sclk !== cpol)) inv_err[k]++;
      if (done) begin
         done_cnt[k]++;
         if (!(cs && !prev_cs[k])) inv_err[k]++;
      end
      if (!cs) begin
         if (prev_cs[k]) begin
            last_gap[k] = highcnt[k];
            lowcnt[k]   = 0;
         end
         lowcnt[k]++;
         samp = cpha ? (prev_sclk[k] != cpol && sclk == cpol)
                     : (prev_sclk[k] == cpol && sclk != cpol);
         if (samp) begin
            sh[k] = {sh[k][30:0], mosi};
            bitcnt[k]++;
            if (bitcnt[k] == w) begin
               bitcnt[k] = 0;
               pop_word(k, v, ok);
               if (!ok) check($sformatf("word_unexpected%0d", k), sh[k] & mask, 32'hFFFF_FFFF);
               else     check($sformatf("word%0d", k), sh[k] & mask, v);
            end
         end
      end else begin
         if (!prev_cs[k]) begin
            pop_len(k, l, ok);
            if (!ok) check($sformatf("frame_unexpected%0d", k), lowcnt[k], 0);
            else     check($sformatf("cs_low_len%0d", k), lowcnt[k], l);
            check($sformatf("partial_bits%0d", k), bitcnt[k], 0);
            bitcnt[k]  = 0;
            highcnt[k] = 0;
         end
         highcnt[k]++;
      end
      prev_cs[k]   = cs;
      prev_sclk[k] = sclk;
   endtask

   always @(negedge clk) begin
      mon(0, cs0, sclk0, mosi0, busy0, done0, 1'b0, 1'b0, W0);
      mon(1, cs1, sclk1, mosi1, busy1, done1, 1'b1, 1'b1, W1);
   end

   // driver tasks
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int k, input int target, input int budget, input string name);
      int t;
      t = 0;
      while (done_cnt[k] < target && t < budget) begin
         @(posedge clk);
         t++;
      end
      #1;
      check(name, 32'(done_cnt[k] >= target), 1);
   endtask

   task automatic wait_busy(input int k, input int budget, input string name);
      int t;
      t = 0;
      while (((k == 0) ? busy0 : busy1) !== 1'b1 && t < budget) begin
         @(posedge clk);
         #1;
         t++;
      end
      check(name, (k == 0) ? busy0 : busy1, 1);
   endtask

   logic [31:0] el[8];
   int          target, t, dc;

   initial begin
      rst_l = 1'b0;
      tick(3);
      check("rst_cs0", cs0, 1);
      check("rst_sclk0", sclk0, 0);
      check("rst_mosi0", mosi0, 0);
      check("rst_busy0", busy0, 0);
      check("rst_done0", done0, 0);
      check("rst_state0", st0, 0);
      check("rst_sclk1", sclk1, 1);
      check("rst_cs1", cs1, 1);
      rst_l = 1'b1;
      tick(2);

      // full frame, plus a start pulse while busy that must be ignored
      bus0 = 64'h0807_0605_0403_0201;
      el = '{32'h01, 32'h02, 32'h03, 32'h04, 32'h05, 32'h06, 32'h07, 32'h08};
      push_expect(0, el, 8, W0, GAP0, CPHB0);
      start0 = 1'b1;
      tick(1);
      start0 = 1'b0;
      check("t1_busy_next_cycle", busy0, 1);
      tick(40);
      start0 = 1'b1;
      tick(1);
      start0 = 1'b0;
      wait_done(0, 1, 2000, "t1_done");
      tick(30);
      check("t1_idle_after", {busy0, cs0}, 2'b01);
      check("t1_done_count", done_cnt[0], 1);
      check("t1_words_left", exp0_q.size(), 0);
      check("t1_lens_left", len0_q.size(), 0);

      // half spectrum; half_only dropped right after acceptance
      half0 = 1'b1;
      push_expect(0, el, 4, W0, GAP0, CPHB0);
      start0 = 1'b1;
      tick(1);
      start0 = 1'b0;
      half0  = 1'b0;
      wait_done(0, 2, 2000, "t2_done");
      tick(5);
      check("t2_done_count", done_cnt[0], 2);
      check("t2_words_left", exp0_q.size(), 0);

      // start held for two frames, bus changed during the first
      bus0 = 64'h1716_1514_1312_1110;
      el = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'h17};
      push_expect(0, el, 8, W0, GAP0, CPHB0);
      start0 = 1'b1;
      tick(21);
      bus0 = 64'h8786_8584_8382_8180;
      el = '{32'h80, 32'h81, 32'h82, 32'h83, 32'h84, 32'h85, 32'h86, 32'h87};
      push_expect(0, el, 8, W0, GAP0, CPHB0);
      wait_done(0, 3, 2000, "t3_done1");
      wait_busy(0, 10, "t3_restart");
      @(negedge clk);
      #1;
      check("t3_cs_high_between", last_gap[0], 2);
      start0 = 1'b0;
      wait_done(0, 4, 2000, "t3_done2");
      tick(30);
      check("t3_done_count", done_cnt[0], 4);
      check("t3_idle_after", {busy0, cs0}, 2'b01);
      check("t3_words_left", exp0_q.size(), 0);

      // asynchronous reset in the middle of word 3
      bus0 = 64'h0807_0605_0403_0201;
      el = '{32'h01, 32'h02, 32'h03, 32'h04, 32'h05, 32'h06, 32'h07, 32'h08};
      push_expect(0, el, 8, W0, GAP0, CPHB0);
      target = exp0_q.size() - 3;
      start0 = 1'b1;
      tick(1);
      start0 = 1'b0;
      t = 0;
      while (exp0_q.size() > target && t < 2000) begin
         @(posedge clk);
         t++;
      end
      tick(12);
      check("t4_in_shift", st0, 2);
      dc = done_cnt[0];
      #2 rst_l = 1'b0;
      #1;
      check("t4_rst_cs", cs0, 1);
      check("t4_rst_sclk", sclk0, 0);
      check("t4_rst_mosi", mosi0, 0);
      check("t4_rst_busy", busy0, 0);
      tick(3);
      exp0_q.delete();
      len0_q.delete();
      rst_l = 1'b1;
      tick(50);
      check("t4_no_done", done_cnt[0], dc);
      check("t4_cs_stays_high", cs0, 1);

      // CPOL=1 / CPHA=1, 12-bit words, no inter-word gap
      check("t5_sclk_idle_before", sclk1, 1);
      bus1 = 24'h123_ABC;
      el = '{32'hABC, 32'h123, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      push_expect(1, el, 2, W1, GAP1, CPHB1);
      start1 = 1'b1;
      tick(1);
      start1 = 1'b0;
      wait_done(1, 1, 2000, "t5_done");
      tick(5);
      check("t5_sclk_idle_after", sclk1, 1);
      check("t5_words_left", exp1_q.size(), 0);
      check("t5_done_count", done_cnt[1], 1);

      check("invariants0", inv_err[0], 0);
      check("invariants1", inv_err[1], 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      n_tests++;
      n_fail++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fft_spi_stream_out.md
Name: fft_spi_stream_out

Overview:
Parametrised successor of the FFT SPI output stage. It snapshots the whole FFT result bus on a start request and streams it over a built-in SPI master as one chip-select frame: a sync header word, then 2N (or N) data words, then an optional CRC. It generalises word width, SPI mode and bit rate, and adds a busy/done handshake and half-spectrum mode. It sits after the last FFT stage and drives the board SPI pins directly.

Parameters:
N, 16, FFT points; the bus carries 2N words (real/imag interleaved, element i at bits [(i+1)*W-1:i*W])
W, 8, bits per word; legal 8..32
CPOL, 0, SCLK idle level
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
CLKS_PER_HALF_BIT, 2, clk cycles per SCLK half period; legal >=2
GAP_HALF_BITS, 2, idle half-bit periods between words, CS held low; legal >=0
SYNC_WORD, 8'hA5, header word, zero-extended to W

Ports:
clk  input  1  system clock
rst_l  input  1  asynchronous active-low reset
data_bus  input  N*2*W  FFT result bus; sampled only on start acceptance
start_spi  input  1  frame request; level-sampled
half_only  input  1  sampled with data_bus; 1 = send elements 0..N-1 only
busy  output  1  frame in progress
done  output  1  one-cycle pulse at frame end
sclk  output  1  SPI clock
mosi  output  1  SPI data, MSB first
cs  output  1  active-low chip select

Behaviour:
- Reset (async, rst_l=0): sclk=CPOL, mosi=0, cs=1, busy=0, done=0; state IDLE; counters cleared. Reset mid-frame aborts immediately with these values and sends no partial word afterwards.
- Accept: start_spi=1 in IDLE -> snapshot data_bus and half_only, busy=1 from the next cycle. start_spi is ignored in every other state. If start_spi is held, a new frame starts on the first IDLE cycle after done.
- Word sequence: SYNC_WORD, elements 0..E-1 (E=2N, or N if half_only), then the CRC word if enabled. Word counter width is $clog2(2N+2).
- States: IDLE -> CS_SETUP (cs=0, 1 half-bit) -> SHIFT (2W half-bits per word) -> GAP (GAP_HALF_BITS, sclk idle; skipped when 0) -> back to SHIFT, or to CS_HOLD after the last word -> CS_HOLD (1 half-bit, cs=0) -> DONE (cs=1, done=1, busy=0, 1 cycle) -> IDLE.
- Timing: the half-bit counter counts 0..CLKS_PER_HALF_BIT-1 and SCLK toggles on its wrap during SHIFT only.
  - CPHA=0: mosi presents the bit in the CS_SETUP/GAP half-bit before the first edge and changes on each trailing edge.
  - CPHA=1: mosi changes on each leading edge.
  - SCLK returns to CPOL after each word.
- Frame length, with words = 1+E(+1) and H = 2 + words*2W + (words-1)*GAP_HALF_BITS half-bits: cs is low for exactly H*CLKS_PER_HALF_BIT cycles. done occurs on the cycle cs rises.
- mosi = 0 whenever cs=1.
- Snapshot isolation: changes on data_bus during a frame do not affect transmitted data.

Optional Feature:
FFT_SPI_CRC8_EN
- Defined: a CRC-8 (poly 0x07, init 0x00, MSB-first) runs over every bit of the data words; the sync word is excluded. The CRC is appended as the final word, in the low 8 bits with the upper W-8 bits zero, and words includes it.
- Undefined: no CRC word, no CRC logic.

Decomposition:
- Shared package fft_spi_pkg:
  - state encoding (IDLE, CS_SETUP, SHIFT, GAP, CS_HOLD, DONE)
  - CRC8_POLY=8'h07
  - default SYNC_WORD
  - frame-length helper function for the bench
- Sub-module spi_word_tx: holds the W-bit shift register, the half-bit counter and SCLK/mosi generation for one word. It takes load/word and returns word_done. The top module holds the snapshot, sequencing, cs and CRC.

Test Plan:
- Reset during SHIFT of word 3 -> same cycle: cs=1, sclk=CPOL, mosi=0, busy=0. No done pulse.
- N=4, W=8, CPOL=0, CPHA=0, CLKS_PER_HALF_BIT=2, GAP=2, bus elements 0x01..0x08, start pulse -> captured bytes A5,01..08. cs low 324 cycles. One done pulse. busy high until done.
- Same config with half_only=1 -> bytes A5,01,02,03,04. cs low (2+80+8)*2=180 cycles.
- CPOL=1, CPHA=1, W=12, data 0xABC -> slave sampling on rising (trailing) edges reads 0xABC. sclk idles high before and after the frame.
- start_spi held high for 2 frames, with data_bus changed mid-frame -> frame 1 carries the old snapshot. Frame 2 starts the cycle after done and carries the new data. Pulses during busy are ignored.
- FFT_SPI_CRC8_EN defined, N=2, data 01,02,03,04 -> words A5,01,02,03,04, then a CRC word that matches the bench model. cs low time includes the extra word.
